// File: rtl/div_unit_if.sv
// div_unit_if: operand/result bundle between the execute stage and the divider
interface div_unit_if;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        div_ready;
  modport master (output start, annul, signed_div, opdata1, opdata2, input result, div_ready);
  modport slave (input start, annul, signed_div, opdata1, opdata2, output result, div_ready);
endinterface

// File: rtl/div_unit.sv
// div_unit: 32-bit signed/unsigned restoring divider, one quotient bit per cycle
// Build option DIV_BYZERO_FAST_EN: a zero divisor completes in one cycle
module div_unit (
  input logic clk,
  input logic rst,
  div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} divState;
  divState state, nextState;
  logic [31:0] rem, quo, dvs, absA, absB, remNext, quoNext, remFix, quoFix;
  logic [32:0] shifted;
  logic [63:0] resultReg;
  logic [4:0] count;
  logic negQ, negR, geq, accept;
  assign absA = (bus.signed_div && bus.opdata1[31]) ? -bus.opdata1 : bus.opdata1;
  assign absB = (bus.signed_div && bus.opdata2[31]) ? -bus.opdata2 : bus.opdata2;
  assign accept = state == IDLE && bus.start && !bus.annul;
  // A zero divisor needs no special case here: every trial succeeds, giving
  // quotient all-ones and remainder |dividend|, which sign correction finishes.
  assign shifted = {rem, quo[31]};
  assign geq = shifted >= {1'b0, dvs};
  assign remNext = geq ? 32'(shifted - {1'b0, dvs}) : shifted[31:0];
  assign quoNext = {quo[30:0], geq};
  assign quoFix = negQ ? -quoNext : quoNext;
  assign remFix = negR ? -remNext : remNext;
  assign bus.result = resultReg;
  assign bus.div_ready = state == DONE;
  always_comb begin
    nextState = state;
    case (state)
`ifdef DIV_BYZERO_FAST_EN
      IDLE: nextState = bus.start ? ((bus.opdata2 == 32'h0) ? DONE : BUSY) : IDLE;
`else
      IDLE: nextState = bus.start ? BUSY : IDLE;
`endif
      BUSY: nextState = (count == 5'd31) ? DONE : BUSY;
      default: nextState = IDLE;
    endcase
    if (bus.annul) nextState = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      resultReg <= 64'h0;
      count <= 5'd0;
      rem <= 32'h0;
      quo <= 32'h0;
      dvs <= 32'h0;
      negQ <= 1'b0;
      negR <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        rem <= 32'h0;
        quo <= absA;
        dvs <= absB;
        count <= 5'd0;
        negQ <= bus.signed_div && (bus.opdata1[31] ^ bus.opdata2[31]);
        negR <= bus.signed_div && bus.opdata1[31];
`ifdef DIV_BYZERO_FAST_EN
        if (bus.opdata2 == 32'h0)
          resultReg <= {bus.opdata1, (bus.signed_div && bus.opdata1[31]) ? 32'h00000001 : 32'hFFFFFFFF};
`endif
      end
      if (state == BUSY) begin
        rem <= remNext;
        quo <= quoNext;
        count <= count + 5'd1;
        if (count == 5'd31 && !bus.annul) resultReg <= {remFix, quoFix};
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of latency, results, annul and reset for div_unit
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  div_unit_if bus ();
  div_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
`ifdef DIV_BYZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Holds start until div_ready, scrambling operands each cycle to prove they were latched.
  task automatic runOp(input string tag, input logic sd, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat);
    int n = 0;
    bus.signed_div = sd;
    bus.opdata1 = a;
    bus.opdata2 = b;
    bus.start = 1'b1;
    do begin
      step();
      n++;
      bus.opdata1 = $urandom;
      bus.opdata2 = $urandom;
      bus.signed_div = ~bus.signed_div;
    end while (!bus.div_ready && n < 100);
    bus.start = 1'b0;
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_res"}, bus.result, exp);
    step();
    check({tag, "_pulse"}, {63'h0, bus.div_ready}, 64'h0);
  endtask
  task automatic quiet(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      seen |= bus.div_ready;
    end
    check({tag, "_quiet"}, {63'h0, seen}, 64'h0);
  endtask
  initial begin
    logic [63:0] held;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'h0;
    bus.opdata2 = 32'h0;
    step();
    step();
    rst = 1'b0;
    check("rst_result", bus.result, 64'h0);
    check("rst_ready", {63'h0, bus.div_ready}, 64'h0);
    runOp("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    runOp("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    runOp("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33);
    runOp("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
    runOp("divu_min_max", 1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 33);
    runOp("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 33);
    runOp("div_byzero", 1'b1, 32'hFFFFFFF0, 32'h0, {32'hFFFFFFF0, 32'h00000001}, ZLAT);
    runOp("divu_byzero", 1'b0, 32'd5, 32'h0, {32'd5, 32'hFFFFFFFF}, ZLAT);
    runOp("b2b_15_4", 1'b0, 32'd15, 32'd4, {32'd3, 32'd3}, 33);
    runOp("b2b_20_6", 1'b0, 32'd20, 32'd6, {32'd2, 32'd3}, 33);
    held = bus.result;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd100;
    bus.opdata2 = 32'd7;
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus.annul = 1'b1;
    bus.start = 1'b0;
    step();
    bus.annul = 1'b0;
    check("annul_ready", {63'h0, bus.div_ready}, 64'h0);
    check("annul_result", bus.result, held);
    quiet("annul", 40);
    check("annul_hold", bus.result, held);
    runOp("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
    bus.opdata1 = 32'd50;
    bus.opdata2 = 32'd5;
    bus.start = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    bus.start = 1'b0;
    step();
    rst = 1'b0;
    check("midrst_result", bus.result, 64'h0);
    check("midrst_ready", {63'h0, bus.div_ready}, 64'h0);
    quiet("midrst", 40);
    runOp("after_rst_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
